// File: rtl/banked_mem_responder_pkg.sv
// Shared definitions for the banked memory responder and the cache FSM that drives it.
// Contents: bank count, where the bank-select field sits in the byte address,
// default latencies, and the request classification used by the top-level decode.
package banked_mem_responder_pkg;

    localparam int NUM_BANKS        = 4;
    localparam int BANK_W           = 2;
    // Bank index is addr[2:1]; the word index within a bank is everything above it.
    localparam int BANK_SEL_LSB     = 1;
    localparam int WORD_SEL_LSB     = BANK_SEL_LSB + BANK_W;
    localparam int DEF_BANK_LAT     = 4;
    localparam int DEF_RD_LAT       = 2;

    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_RD      = 2'd1,
        REQ_WR      = 2'd2,
        REQ_ILLEGAL = 2'd3
    } req_kind_e;

endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bus between the cache controller (master) and the banked
// memory responder (slave).
//   addr, data_in, wr, rd        : request from master
//   data_out, rd_valid           : read return
//   stall, busy, err             : flow control / status back to master
interface banked_mem_responder_if
    import banked_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 wr;
    logic                 rd;
    logic [DATA_W-1:0]    data_out;
    logic                 rd_valid;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, stall, busy, err
    );
endinterface

// File: rtl/banked_mem_responder_bank.sv
// One memory bank: word storage plus an occupancy down-counter.
//   clk, rst   : clock, asynchronous active-low reset (counter only; storage is not reset)
//   accept     : an access to this bank is taken this cycle
//   wr_en      : the accepted access is a write
//   word       : word index within the bank
//   wdata      : write data
//   rdata      : combinational read of the addressed word
//   busy       : bank occupied (counter non-zero)
module banked_mem_responder_bank #(
    parameter int WORD_W   = 13,
    parameter int DATA_W   = 16,
    parameter int BANK_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(BANK_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_LAT - 1);

    logic [DATA_W-1:0] mem [0:(2**WORD_W)-1];
    logic [CNT_W-1:0]  cnt;

    // The accept cycle itself counts as the first occupied cycle, so the
    // counter covers the remaining BANK_LAT-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wr_en) begin
            mem[word] <= wdata;
        end
    end

    assign rdata = mem[word];
    assign busy  = (cnt != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-way word-interleaved memory responder for cache line fill / writeback.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of banked_mem_responder_if (request in, read data,
//              stall, per-bank busy and illegal-request error out)
// A legal request to an idle bank is accepted the cycle it is presented; reads
// return RD_LAT cycles later through a registered shift pipe.
module banked_mem_responder
    import banked_mem_responder_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int BANK_LAT = DEF_BANK_LAT,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    banked_mem_responder_if.slave  bus
);
    localparam int WORD_W = ADDR_W - WORD_SEL_LSB;

    req_kind_e            kind;
    logic [BANK_W-1:0]    sel;
    logic [WORD_W-1:0]    word;
    logic                 legal_req;
    logic                 target_busy;
    logic                 accept;
    logic                 rd_accept;
    logic [NUM_BANKS-1:0] acc_vec;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [DATA_W-1:0]    rdata [NUM_BANKS];
    logic [RD_LAT-1:0]    pipe_vld;
    logic [DATA_W-1:0]    pipe_dat [RD_LAT];
    logic                 err_q;

    // Illegal requests are classified first so they never raise stall.
    always_comb begin
        kind = REQ_NONE;
        if ((bus.rd && bus.wr) || ((bus.rd || bus.wr) && bus.addr[0])) begin
            kind = REQ_ILLEGAL;
        end else if (bus.rd) begin
            kind = REQ_RD;
        end else if (bus.wr) begin
            kind = REQ_WR;
        end
    end

    assign sel         = bus.addr[BANK_SEL_LSB +: BANK_W];
    assign word        = bus.addr[ADDR_W-1:WORD_SEL_LSB];
    assign legal_req   = (kind == REQ_RD) || (kind == REQ_WR);
    assign target_busy = busy_vec[sel];
    assign accept      = legal_req && !target_busy;
    assign rd_accept   = accept && (kind == REQ_RD);
    assign bus.stall   = legal_req && target_busy;

    always_comb begin
        acc_vec      = '0;
        acc_vec[sel] = accept;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        banked_mem_responder_bank #(
            .WORD_W   (WORD_W),
            .DATA_W   (DATA_W),
            .BANK_LAT (BANK_LAT)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .accept (acc_vec[b]),
            .wr_en  (kind == REQ_WR),
            .word   (word),
            .wdata  (bus.data_in),
            .rdata  (rdata[b]),
            .busy   (busy_vec[b])
        );
    end

    // Data stages carry zero when their valid is low, so the last stage can
    // drive data_out directly and still read 0 outside a rd_valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            pipe_vld[0] <= rd_accept;
            pipe_dat[0] <= rd_accept ? rdata[sel] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
            err_q <= (kind == REQ_ILLEGAL);
        end
    end

    assign bus.rd_valid = pipe_vld[RD_LAT-1];
    assign bus.data_out = pipe_dat[RD_LAT-1];
    assign bus.busy     = busy_vec;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench for banked_mem_responder. Reads push their expected word
// and return cycle onto a scoreboard; a negedge monitor pops and compares on
// every rd_valid pulse and flags any pulse nobody asked for.
module tb_banked_mem_responder;
    import banked_mem_responder_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int BANK_LAT = 4;
    localparam int RD_LAT   = 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [DATA_W-1:0] model [int];

    banked_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    banked_mem_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BANK_LAT (BANK_LAT),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_rd_valid cycle=%0d data_out=%h required no pulse", cyc, bus.data_out);
            end else begin
                mon_e = sb.pop_front();
                if (bus.data_out !== mon_e.data || cyc != mon_e.due) begin
                    $display("FAIL rd_data addr=%h got=%h@%0d expected=%h@%0d",
                             mon_e.addr, bus.data_out, cyc, mon_e.data, mon_e.due);
                end else begin
                    pass_cnt++;
                end
            end
        end else begin
            total_cnt++;
            if (bus.data_out !== '0) begin
                $display("FAIL data_out_idle cycle=%0d got=%h expected=0000", cyc, bus.data_out);
            end else begin
                pass_cnt++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a request, holds it through stalls, and records the accept.
    task automatic issue(input bit is_rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         output int stalls, output int acc, output logic [3:0] busy_at);
        bus.rd      = is_rd;
        bus.wr      = !is_rd;
        bus.addr    = a;
        bus.data_in = d;
        stalls      = 0;
        acc         = -1;
        busy_at     = 'x;
        while (acc < 0) begin
            @(negedge clk);
            if (bus.stall === 1'b0) begin
                acc     = cyc;
                busy_at = bus.busy;
                if (is_rd) sb.push_back('{data: model[int'(a)], due: cyc + RD_LAT, addr: a});
                else       model[int'(a)] = d;
            end else begin
                stalls++;
                if (stalls > 3 * BANK_LAT) begin
                    total_cnt++;
                    $display("FAIL issue_timeout addr=%h stalled=%0d cycles required accept", a, stalls);
                    acc = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        total_cnt++;
        if (sb.size() != 0) begin
            $display("FAIL %s_drain outstanding=%0d expected=0", name, sb.size());
            sb.delete();
        end else begin
            pass_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s got=%h expected=%h", name, got, exp);
        else             pass_cnt++;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",     16'(bus.busy),     16'h0);
        chk("reset_rd_valid", 16'(bus.rd_valid), 16'h0);
        chk("reset_data_out", bus.data_out,      16'h0);
        chk("reset_err",      16'(bus.err),      16'h0);
        chk("reset_stall",    16'(bus.stall),    16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        int s, a;
        logic [3:0] b;
        issue(1'b0, 16'h0010, 16'hBEEF, s, a, b);
        chk("basic_wr_stall", 16'(s), 16'h0);
        idle(BANK_LAT);
        issue(1'b1, 16'h0010, 16'h0000, s, a, b);
        chk("basic_rd_stall", 16'(s), 16'h0);
        drain("basic");
    endtask

    task automatic test_line_fill();
        int s, a;
        logic [3:0] b;
        logic [3:0] exp_busy [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110};
        issue(1'b0, 16'h0108, 16'hC0DE, s, a, b);
        for (int i = 0; i < 4; i++) issue(1'b0, 16'(16'h0100 + 2*i), 16'(16'hA0A0 + i), s, a, b);
        idle(BANK_LAT);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 16'(16'h0100 + 2*i), 16'h0000, s, a, b);
            chk("fill_stall", 16'(s), 16'h0);
            chk("fill_busy",  16'(b), 16'(exp_busy[i]));
        end
        // Bank 0 frees BANK_LAT cycles after its accept, as bank 3 becomes busy.
        @(negedge clk);
        chk("fill_busy_last", 16'(bus.busy), 16'(exp_busy[4]));
        drain("fill");
    endtask

    task automatic test_conflict();
        int s0, a0, s1, a1;
        logic [3:0] b;
        idle(BANK_LAT);
        issue(1'b1, 16'h0100, 16'h0000, s0, a0, b);
        issue(1'b1, 16'h0108, 16'h0000, s1, a1, b);
        chk("conflict_stalls", 16'(s1), 16'd3);
        chk("conflict_accept", 16'(a1 - a0), 16'(BANK_LAT));
        drain("conflict");
    endtask

    task automatic test_illegal();
        int s, a;
        logic [3:0] b;
        logic [2:0] cases [3] = '{3'b110, 3'b101, 3'b011}; // {rd, wr, addr[0]}
        issue(1'b0, 16'h0020, 16'h5A5A, s, a, b);
        idle(BANK_LAT);
        for (int i = 0; i < 3; i++) begin
            bus.rd      = cases[i][2];
            bus.wr      = cases[i][1];
            bus.addr    = 16'h0020 | 16'(cases[i][0]);
            bus.data_in = 16'hDEAD;
            @(negedge clk);
            chk("illegal_stall",   16'(bus.stall), 16'h0);
            chk("illegal_err_pre", 16'(bus.err),   16'h0);
            @(posedge clk);
            #1;
            bus.rd = 1'b0;
            bus.wr = 1'b0;
            @(negedge clk);
            chk("illegal_err",  16'(bus.err),  16'h1);
            chk("illegal_busy", 16'(bus.busy), 16'h0);
            @(negedge clk);
            chk("illegal_err_clear", 16'(bus.err), 16'h0);
            @(posedge clk);
            #1;
        end
        issue(1'b1, 16'h0020, 16'h0000, s, a, b);
        drain("illegal_readback");
    endtask

    task automatic test_reset_mid();
        int s, a;
        logic [3:0] b;
        idle(BANK_LAT);
        issue(1'b1, 16'h0010, 16'h0000, s, a, b);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy_in_reset", 16'(bus.busy), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_busy_after", 16'(bus.busy), 16'h0);
        @(posedge clk);
        #1;
        issue(1'b1, 16'h0010, 16'h0000, s, a, b);
        chk("midrst_rd_stall", 16'(s), 16'h0);
        drain("midrst_readback");
    endtask

    task automatic test_line_rw();
        int s, a;
        logic [3:0] b;
        idle(BANK_LAT);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 16'(16'h0200 + 2*i), 16'(16'h1111 * (i + 1)), s, a, b);
            chk("linerw_wr_stall", 16'(s), 16'h0);
        end
        idle(BANK_LAT);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 16'(16'h0200 + 2*i), 16'h0000, s, a, b);
            chk("linerw_rd_stall", 16'(s), 16'h0);
        end
        drain("linerw");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_line_fill();
        test_conflict();
        test_illegal();
        test_reset_mid();
        test_line_rw();
        idle(4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
